// File: rtl/rs_dsp2_div_pkg.sv
// rs_dsp2_div_pkg: shared state encoding, default widths and sign helper for the RS_DSP2 divider
package rs_dsp2_div_pkg;
  localparam int Q_WIDTH_DEF = 20;
  localparam int D_WIDTH_DEF = 18;
  localparam int Z_WIDTH_DEF = Q_WIDTH_DEF + D_WIDTH_DEF;
  localparam int W_MAX = 64;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  // Two's complement negate when s is set; doubles as abs() when s is the operand sign
  function automatic logic [W_MAX-1:0] cond_neg(input logic s, input logic [W_MAX-1:0] v);
    return s ? -v : v;
  endfunction
endpackage

// File: rtl/rs_dsp2_div_step.sv
// rs_dsp2_div_step: one combinational restoring-division step
module rs_dsp2_div_step
  import rs_dsp2_div_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF
) (
  input  logic [D_WIDTH-1:0] rem_in,
  input  logic               din,
  input  logic [D_WIDTH-1:0] div,
  output logic [D_WIDTH-1:0] rem_out,
  output logic               q_bit
);
  logic [D_WIDTH:0] sh;
  always_comb begin
    sh      = {rem_in, din};
    q_bit   = sh >= {1'b0, div};
    rem_out = D_WIDTH'(q_bit ? sh - {1'b0, div} : sh);
  end
endmodule

// File: rtl/rs_dsp2_div_iter.sv
// rs_dsp2_div_iter: iterative restoring divider inverting the RS_DSP2 20x18 multiply
module rs_dsp2_div_iter
  import rs_dsp2_div_pkg::*;
#(
  parameter int Q_WIDTH = Q_WIDTH_DEF,
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int Z_WIDTH = Q_WIDTH + D_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [Z_WIDTH-1:0] z,
  input  logic [D_WIDTH-1:0] b,
  input  logic               unsigned_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [Q_WIDTH-1:0] q,
  output logic [D_WIDTH-1:0] r,
  output logic               div_by_zero,
  output logic               overflow
);
  localparam logic [Q_WIDTH-1:0] Q_HALF = Q_WIDTH'(1) << (Q_WIDTH - 1);
  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [D_WIDTH-1:0] rem_q, rem_d, bm_q, bm_d, r_q, r_d;
  logic [Q_WIDTH-1:0] qz_q, qz_d, q_q, q_d;
  logic sq_q, sq_d, sr_q, sr_d, uns_q, uns_d, dbz_q, dbz_d, ovf_q, ovf_d;
  logic sz, sb, step_q, fix_ovf;
  logic [Z_WIDTH-1:0] zm;
  logic [D_WIDTH-1:0] bm_in, step_rem, rs;
  logic [Q_WIDTH-1:0] qs;
  // qz_q holds the unconsumed dividend bits; quotient bits shift in behind them
  rs_dsp2_div_step #(.D_WIDTH(D_WIDTH)) u_step (
    .rem_in (rem_q),
    .din    (qz_q[Q_WIDTH-1]),
    .div    (bm_q),
    .rem_out(step_rem),
    .q_bit  (step_q)
  );
  always_comb begin
    sz      = !unsigned_mode && z[Z_WIDTH-1];
    sb      = !unsigned_mode && b[D_WIDTH-1];
    zm      = Z_WIDTH'(cond_neg(sz, W_MAX'(z)));
    bm_in   = D_WIDTH'(cond_neg(sb, W_MAX'(b)));
    qs      = Q_WIDTH'(cond_neg(sq_q, W_MAX'(qz_q)));
    rs      = D_WIDTH'(cond_neg(sr_q, W_MAX'(rem_q)));
    fix_ovf = !uns_q && (qz_q > (sq_q ? Q_HALF : Q_HALF - Q_WIDTH'(1)));
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    qz_d    = qz_q;
    bm_d    = bm_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    uns_d   = uns_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (in_valid) begin
        sq_d  = sz ^ sb;
        sr_d  = sz;
        uns_d = unsigned_mode;
        bm_d  = bm_in;
        rem_d = zm[Z_WIDTH-1:Q_WIDTH];
        qz_d  = zm[Q_WIDTH-1:0];
        cnt_d = '0;
        if (b == '0) begin
          state_d = DONE;
          dbz_d   = 1'b1;
          q_d     = '1;
          r_d     = z[D_WIDTH-1:0];
        end else if (zm[Z_WIDTH-1:Q_WIDTH] >= bm_in) begin
          state_d = DONE;
          ovf_d   = 1'b1;
          q_d     = '1;
          r_d     = '0;
        end else begin
          state_d = CALC;
        end
      end
      CALC: begin
        rem_d   = step_rem;
        qz_d    = {qz_q[Q_WIDTH-2:0], step_q};
        cnt_d   = cnt_q + 5'd1;
        state_d = cnt_q == 5'(Q_WIDTH - 1) ? FIX : CALC;
      end
      FIX: begin
        state_d = DONE;
        ovf_d   = fix_ovf;
        q_d     = fix_ovf ? '1 : qs;
        r_d     = fix_ovf ? '0 : rs;
      end
      DONE: if (out_ready) begin
        state_d = IDLE;
        q_d     = '0;
        r_d     = '0;
        dbz_d   = 1'b0;
        ovf_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      qz_q    <= '0;
      bm_q    <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      uns_q   <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      qz_q    <= qz_d;
      bm_q    <= bm_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      uns_q   <= uns_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end
  assign in_ready    = state_q == IDLE;
  assign out_valid   = state_q == DONE;
  assign q           = q_q;
  assign r           = r_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
endmodule
